// File: rtl/char_reader_pkg.sv
// char_reader shared types: FSM state encoding and character codes.
package char_reader_pkg;

    typedef enum logic [1:0] {
        CR_IDLE = 2'd0,
        CR_SEND = 2'd1,
        CR_DONE = 2'd2
    } cr_state_e;

    localparam logic [7:0] CHAR_NULL = 8'h00;

endpackage

// File: rtl/char_reader_char_sel.sv
// Combinational byte selector: picks character pos_i out of the snapshot.
// Character 0 occupies the most significant byte of the buffer.
module char_reader_char_sel #(
    parameter  int N_CHARS = 64,
    parameter  int CHAR_W  = 8,
    localparam int PW      = $clog2(N_CHARS)
) (
    input  logic [N_CHARS*CHAR_W-1:0] snap_i,
    input  logic [PW-1:0]             pos_i,
    output logic [CHAR_W-1:0]         char_o
);

    always_comb begin
        char_o = '0;
        for (int i = 0; i < N_CHARS; i++) begin
            if (pos_i == PW'(i)) begin
                char_o = snap_i[(N_CHARS-1-i)*CHAR_W +: CHAR_W];
            end
        end
    end

endmodule

// File: rtl/char_reader.sv
// char_reader: snapshots the text buffer on start and streams it out per char.
// Define CHAR_READER_SKIP_NULL_EN to skip Null characters without a handshake.
module char_reader
    import char_reader_pkg::*;
#(
    parameter  int N_CHARS = 64,
    parameter  int CHAR_W  = 8,
    localparam int PW      = $clog2(N_CHARS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_CHARS*CHAR_W-1:0] c_data,
    input  logic                      tx_ready,
    output logic                      tx_valid,
    output logic [CHAR_W-1:0]         tx_char,
    output logic [PW-1:0]             tx_pos,
    output logic                      busy,
    output logic                      print_fin
);

    cr_state_e                 state_q;
    logic [PW-1:0]             pos_q;
    logic [N_CHARS*CHAR_W-1:0] snap_q;

    logic [CHAR_W-1:0] sel_char;
    logic              send;
    logic              skip;
    logic              advance;
    logic              last;

    char_reader_char_sel #(
        .N_CHARS (N_CHARS),
        .CHAR_W  (CHAR_W)
    ) u_char_sel (
        .snap_i (snap_q),
        .pos_i  (pos_q),
        .char_o (sel_char)
    );

    assign send = (state_q == CR_SEND);

`ifdef CHAR_READER_SKIP_NULL_EN
    assign skip = send && (sel_char == CHAR_W'(CHAR_NULL));
`else
    assign skip = 1'b0;
`endif

    assign tx_valid  = send && !skip;
    assign tx_char   = send ? sel_char : '0;
    assign tx_pos    = send ? pos_q : '0;
    assign busy      = (state_q != CR_IDLE);
    assign print_fin = (state_q == CR_DONE);

    // A skipped Null moves on exactly like an accepted character.
    assign advance = (tx_valid && tx_ready) || skip;
    assign last    = (pos_q == PW'(N_CHARS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CR_IDLE;
            pos_q   <= '0;
            snap_q  <= '0;
        end else begin
            unique case (state_q)
                CR_IDLE: begin
                    if (start) begin
                        snap_q  <= c_data;
                        pos_q   <= '0;
                        state_q <= CR_SEND;
                    end
                end
                CR_SEND: begin
                    if (advance) begin
                        if (last) begin
                            state_q <= CR_DONE;
                        end else begin
                            pos_q <= pos_q + PW'(1);
                        end
                    end
                end
                CR_DONE: begin
                    state_q <= CR_IDLE;
                end
                default: begin
                    state_q <= CR_IDLE;
                end
            endcase
        end
    end

endmodule
